// File: rtl/noc_packetizer_pkg.sv
// Shared types and header field geometry for the NoC packetizer.
// NOC_PKT_CHECKSUM_EN (when defined) enables the trailing XOR checksum flit.
package noc_packetizer_pkg;

  localparam int unsigned NOC_DATA_W = 32;
  localparam int unsigned HDR_DEST_W = 8;
  localparam int unsigned HDR_SRC_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2,
    S_CSUM = 2'd3
  } pkt_state_e;

  typedef struct packed {
    logic is_header;
    logic is_tail;
  } flit_side_t;

endpackage

// File: rtl/noc_flit_reg.sv
// Output holding register: a valid/ready slice carrying a flit plus header/tail sideband.
// A flit moves only when both ready and vc_ready are high; valid never depends on either.
module noc_flit_reg
  import noc_packetizer_pkg::*;
#(
  parameter int unsigned DATA_W = NOC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_flit,
  input  flit_side_t        load_side,
  input  logic              ready,
  input  logic              vc_ready,
  output logic              valid,
  output logic [DATA_W-1:0] flit,
  output flit_side_t        side,
  output logic              xfer_c,
  output logic              slot_free_c
);

  assign xfer_c      = valid && ready && vc_ready;
  assign slot_free_c = !valid || xfer_c;

  // Contents only change on load, so a stalled flit stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      flit  <= '0;
      side  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      flit  <= load_flit;
      side  <= load_side;
    end else if (xfer_c) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Turns a (dest, len) command plus a payload stream into header/body flits for the NoC.
// Define NOC_PKT_CHECKSUM_EN to append an XOR-of-payload checksum flit carrying the tail.
module noc_packetizer
  import noc_packetizer_pkg::*;
#(
  parameter int unsigned DATA_W = NOC_DATA_W,
  parameter int unsigned LEN_W  = 8,
  parameter logic [HDR_SRC_W-1:0] SRC_ID = 8'h00
) (
  input  logic                  noc_clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [HDR_DEST_W-1:0] pkt_dest,
  input  logic [LEN_W-1:0]      pkt_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_W-1:0]     data_word,
  output logic                  Noc_sender_valid,
  input  logic                  Noc_sender_ready,
  input  logic                  Noc_sender_VCready,
  output logic [DATA_W-1:0]     Noc_sender_flit,
  output logic                  Noc_sender_is_header,
  output logic                  Noc_sender_is_tail
);

  pkt_state_e        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              pkt_ready_d;
  logic              data_ready_c;
  logic              load_c;
  logic [DATA_W-1:0] load_flit_c;
  flit_side_t        load_side_c;
  logic [DATA_W-1:0] header_c;
  logic              xfer_c;
  logic              slot_free_c;
  flit_side_t        out_side;
`ifdef NOC_PKT_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
  logic              csum_sent_q, csum_sent_d;
`endif

  always_comb begin : hdr_build
    header_c = '0;
    header_c[DATA_W-1 -: HDR_DEST_W]            = pkt_dest;
    header_c[DATA_W-HDR_DEST_W-1 -: HDR_SRC_W]  = SRC_ID;
    header_c[LEN_W-1:0]                         = pkt_len;
  end

  // Payload may enter the slot in the same cycle the header drains, so HEAD also accepts data.
  always_comb begin : fsm_next
    state_d      = state_q;
    remaining_d  = remaining_q;
    data_ready_c = 1'b0;
    load_c       = 1'b0;
    load_flit_c  = '0;
    load_side_c  = '0;
`ifdef NOC_PKT_CHECKSUM_EN
    csum_d       = csum_q;
    csum_sent_d  = csum_sent_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pkt_valid && pkt_ready) begin
          load_c                = 1'b1;
          load_flit_c           = header_c;
          load_side_c.is_header = 1'b1;
`ifdef NOC_PKT_CHECKSUM_EN
          load_side_c.is_tail   = 1'b0;
          csum_d                = '0;
          csum_sent_d           = 1'b0;
`else
          load_side_c.is_tail   = (pkt_len == '0);
`endif
          remaining_d           = pkt_len;
          state_d               = S_HEAD;
        end
      end

      S_HEAD, S_BODY: begin
        data_ready_c = (remaining_q != '0) && slot_free_c && !rst;
        if (data_ready_c && data_valid) begin
          load_c              = 1'b1;
          load_flit_c         = data_word;
          remaining_d         = remaining_q - LEN_W'(1);
`ifdef NOC_PKT_CHECKSUM_EN
          load_side_c.is_tail = 1'b0;
          csum_d              = csum_q ^ data_word;
`else
          load_side_c.is_tail = (remaining_q == LEN_W'(1));
`endif
        end

        if (state_q == S_HEAD) begin
          if (xfer_c) begin
`ifdef NOC_PKT_CHECKSUM_EN
            state_d = (remaining_d == '0) ? S_CSUM : S_BODY;
`else
            state_d = (remaining_q == '0) ? S_IDLE : S_BODY;
`endif
          end
        end else begin
`ifdef NOC_PKT_CHECKSUM_EN
          if (remaining_d == '0) begin
            state_d = S_CSUM;
          end
`else
          if ((remaining_q == '0) && xfer_c) begin
            state_d = S_IDLE;
          end
`endif
        end
      end

`ifdef NOC_PKT_CHECKSUM_EN
      S_CSUM: begin
        if (!csum_sent_q && slot_free_c) begin
          load_c              = 1'b1;
          load_flit_c         = csum_q;
          load_side_c.is_tail = 1'b1;
          csum_sent_d         = 1'b1;
        end else if (csum_sent_q && xfer_c) begin
          state_d = S_IDLE;
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    pkt_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge noc_clk) begin : state_reg
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      pkt_ready   <= 1'b0;
`ifdef NOC_PKT_CHECKSUM_EN
      csum_q      <= '0;
      csum_sent_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      pkt_ready   <= pkt_ready_d;
`ifdef NOC_PKT_CHECKSUM_EN
      csum_q      <= csum_d;
      csum_sent_q <= csum_sent_d;
`endif
    end
  end

  assign data_ready = data_ready_c;

  noc_flit_reg #(
    .DATA_W (DATA_W)
  ) u_flit_reg (
    .clk         (noc_clk),
    .rst         (rst),
    .load        (load_c),
    .load_flit   (load_flit_c),
    .load_side   (load_side_c),
    .ready       (Noc_sender_ready),
    .vc_ready    (Noc_sender_VCready),
    .valid       (Noc_sender_valid),
    .flit        (Noc_sender_flit),
    .side        (out_side),
    .xfer_c      (xfer_c),
    .slot_free_c (slot_free_c)
  );

  assign Noc_sender_is_header = out_side.is_header;
  assign Noc_sender_is_tail   = out_side.is_tail;

endmodule

// File: tb/tb_noc_packetizer.sv
// Scoreboard bench for noc_packetizer; expectations come from a packet-level model.
// Honours NOC_PKT_CHECKSUM_EN to match the checksum build of the design.
module tb_noc_packetizer;

`ifdef NOC_PKT_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [7:0] SRC = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  pkt_dest;
  logic [7:0]  pkt_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_word;
  logic        Noc_sender_valid;
  logic        Noc_sender_ready;
  logic        Noc_sender_VCready;
  logic [31:0] Noc_sender_flit;
  logic        Noc_sender_is_header;
  logic        Noc_sender_is_tail;

  typedef struct packed {
    logic [31:0] flit;
    logic        hdr;
    logic        tail;
  } exp_t;

  typedef struct {
    logic [31:0] flit;
    logic        hdr;
    logic        tail;
    int          cyc;
  } rec_t;

  exp_t        exp_q[$];
  rec_t        log_q[$];
  logic [31:0] wbuf [0:15];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          xfer_total = 0;
  int          stall_total = 0;
  int          bp_mode  = 0;

  noc_packetizer dut (
    .noc_clk              (clk),
    .rst                  (rst),
    .pkt_valid            (pkt_valid),
    .pkt_ready            (pkt_ready),
    .pkt_dest             (pkt_dest),
    .pkt_len              (pkt_len),
    .data_valid           (data_valid),
    .data_ready           (data_ready),
    .data_word            (data_word),
    .Noc_sender_valid     (Noc_sender_valid),
    .Noc_sender_ready     (Noc_sender_ready),
    .Noc_sender_VCready   (Noc_sender_VCready),
    .Noc_sender_flit      (Noc_sender_flit),
    .Noc_sender_is_header (Noc_sender_is_header),
    .Noc_sender_is_tail   (Noc_sender_is_tail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Packet-level reference: header, payload words, optional XOR trailer.
  task automatic push_expected(input logic [7:0] dest, input int len);
    logic [31:0] x;
    exp_t e;
    x = '0;
    e.flit = {dest, SRC, 16'h0000} | 32'(len);
    e.hdr  = 1'b1;
    e.tail = !CSUM && (len == 0);
    exp_q.push_back(e);
    for (int i = 0; i < len; i++) begin
      x      = x ^ wbuf[i];
      e.flit = wbuf[i];
      e.hdr  = 1'b0;
      e.tail = !CSUM && (i == len - 1);
      exp_q.push_back(e);
    end
    if (CSUM) begin
      e.flit = x;
      e.hdr  = 1'b0;
      e.tail = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Sink side backpressure: 0 = always ready, 1 = random, 2 = VC stalled.
  initial begin
    Noc_sender_ready   = 1'b0;
    Noc_sender_VCready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        1: begin
          Noc_sender_ready   = ($urandom_range(0, 3) != 0);
          Noc_sender_VCready = ($urandom_range(0, 3) != 0);
        end
        2: begin
          Noc_sender_ready   = 1'b1;
          Noc_sender_VCready = 1'b0;
        end
        default: begin
          Noc_sender_ready   = 1'b1;
          Noc_sender_VCready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks hold-while-stalled.
  initial begin
    exp_t        e;
    rec_t        r;
    logic        stalled = 1'b0;
    logic [33:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", 64'(Noc_sender_valid), 64'd1);
          chk("hold_flit", 64'({Noc_sender_is_header, Noc_sender_is_tail, Noc_sender_flit}), 64'(held));
        end
        if (pkt_ready) chk("idle_no_flit", 64'(Noc_sender_valid), 64'd0);
        if (Noc_sender_valid && Noc_sender_ready && Noc_sender_VCready) begin
          xfer_total++;
          r.flit = Noc_sender_flit;
          r.hdr  = Noc_sender_is_header;
          r.tail = Noc_sender_is_tail;
          r.cyc  = cyc;
          log_q.push_back(r);
          if (exp_q.size() == 0) begin
            chk("unexpected_flit", 64'(Noc_sender_flit), 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            chk("flit_data", 64'(Noc_sender_flit), 64'(e.flit));
            chk("flit_hdr", 64'(Noc_sender_is_header), 64'(e.hdr));
            chk("flit_tail", 64'(Noc_sender_is_tail), 64'(e.tail));
          end
        end
        if (Noc_sender_valid && !Noc_sender_VCready) stall_total++;
        stalled = Noc_sender_valid && !(Noc_sender_ready && Noc_sender_VCready);
        held    = {Noc_sender_is_header, Noc_sender_is_tail, Noc_sender_flit};
      end
    end
  end

  // dv_mode: 0 = data always valid, 1 = toggling, 2 = random. abort_after > 0 stops after that many flits.
  task automatic send_pkt(input logic [7:0] dest, input int len, input int dv_mode, input int abort_after);
    int guard;
    int idx;
    int base;
    bit fired;
    bit tog;
    pkt_dest  = dest;
    pkt_len   = 8'(len);
    pkt_valid = 1'b1;
    guard = 0;
    while (!pkt_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!pkt_ready) begin
      chk("cmd_accept_timeout", 64'(pkt_ready), 64'd1);
      pkt_valid = 1'b0;
      return;
    end
    base = xfer_total;
    push_expected(dest, len);
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    idx = 0;
    guard = 0;
    tog = 1'b0;
    while (idx < len && guard < 400) begin
      if (abort_after > 0 && (xfer_total - base) >= abort_after) break;
      case (dv_mode)
        1:       begin data_valid = tog; tog = !tog; end
        2:       data_valid = 1'($urandom_range(0, 1));
        default: data_valid = 1'b1;
      endcase
      data_word = wbuf[idx];
      @(negedge clk);
      fired = data_valid && data_ready;
      @(posedge clk);
      #1;
      if (fired) idx++;
      guard++;
    end
    data_valid = 1'b0;
    if (abort_after == 0) chk("words_accepted", 64'(idx), 64'(len));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || Noc_sender_valid) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] exp29 [0:3];
    int ls;
    int st;
    exp29[0] = 32'h0500_0003;
    exp29[1] = 32'h0000_000A;
    exp29[2] = 32'h0000_000B;
    exp29[3] = 32'h0000_000C;

    rst = 1'b1; pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0;
    data_valid = 1'b0; data_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_valid", 64'(Noc_sender_valid), 64'd0);
    chk("rst_side", 64'({Noc_sender_is_header, Noc_sender_is_tail}), 64'd0);
    chk("rst_flit", 64'(Noc_sender_flit), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rel_pkt_ready_0", 64'(pkt_ready), 64'd0);
    @(negedge clk);
    chk("rel_pkt_ready_1", 64'(pkt_ready), 64'd1);
    @(posedge clk); #1;

    // Basic 3-word packet at full rate.
    ls = log_q.size();
    wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
    send_pkt(8'h05, 3, 0, 0);
    drain();
    chk("t29_count", 64'(log_q.size() - ls), 64'(4 + int'(CSUM)));
    for (int k = 0; k < 4; k++) begin
      chk("t29_flit", 64'(log_q[ls+k].flit), 64'(exp29[k]));
      if (k > 0) chk("t29_back_to_back", 64'(log_q[ls+k].cyc - log_q[ls+k-1].cyc), 64'd1);
    end
    chk("t29_hdr", 64'(log_q[ls].hdr), 64'd1);
    chk("t29_tail", 64'(log_q[ls+3].tail), 64'(!CSUM));

    // Zero-length packet.
    ls = log_q.size();
    send_pkt(8'h05, 0, 0, 0);
    drain();
    chk("t30_count", 64'(log_q.size() - ls), 64'(1 + int'(CSUM)));
    chk("t30_flit", 64'(log_q[ls].flit), 64'h0500_0000);
    chk("t30_hdr", 64'(log_q[ls].hdr), 64'd1);
    chk("t30_tail", 64'(log_q[ls].tail), 64'(!CSUM));

    // VC stall of three cycles in the middle of the body.
    ls = log_q.size();
    st = stall_total;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h1000 + 32'(i);
    fork
      send_pkt(8'h05, 4, 0, 0);
      begin : stall_ctl
        int g;
        g = 0;
        while ((log_q.size() - ls) < 2 && g < 100) begin
          @(posedge clk); #1; g++;
        end
        bp_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        bp_mode = 0;
      end
    join
    drain();
    chk("t31_count", 64'(log_q.size() - ls), 64'(5 + int'(CSUM)));
    chk("t31_stalled", 64'((stall_total - st) >= 3), 64'd1);
    chk("t31_last_word", 64'(log_q[ls+4].flit), 64'h1003);

`ifdef NOC_PKT_CHECKSUM_EN
    // Checksum trailer.
    ls = log_q.size();
    wbuf[0] = 32'h1; wbuf[1] = 32'h2; wbuf[2] = 32'h4;
    send_pkt(8'h05, 3, 0, 0);
    drain();
    chk("t33_count", 64'(log_q.size() - ls), 64'd5);
    chk("t33_word4", 64'(log_q[ls+3].flit), 64'h4);
    chk("t33_word4_tail", 64'(log_q[ls+3].tail), 64'd0);
    chk("t33_csum", 64'(log_q[ls+4].flit), 64'h7);
    chk("t33_csum_tail", 64'(log_q[ls+4].tail), 64'd1);
`endif

    // Reset in the middle of a 5-word packet.
    for (int i = 0; i < 5; i++) wbuf[i] = 32'h5000 + 32'(i);
    send_pkt(8'h21, 5, 0, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t32_valid_after_rst", 64'(Noc_sender_valid), 64'd0);
    chk("t32_pkt_ready_in_rst", 64'(pkt_ready), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    ls = log_q.size();
    wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    send_pkt(8'h33, 2, 0, 0);
    drain();
    chk("t32_next_hdr", 64'(log_q[ls].flit), 64'h3300_0002);
    chk("t32_next_count", 64'(log_q.size() - ls), 64'(3 + int'(CSUM)));

    // Back-to-back random packets, toggling/random data_valid, random backpressure.
    bp_mode = 1;
    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int i = 0; i < len; i++) wbuf[i] = $urandom;
      send_pkt(8'($urandom_range(0, 255)), len, 1 + (p % 2), 0);
    end
    bp_mode = 0;
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/noc_packetizer.md
NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 SHALL have parameter DATA_W, default `Noc_Data_Width (32), flit and payload word width.
REQ-002 SHALL have parameter LEN_W, default 8, payload-length field width.
REQ-003 SHALL have parameter SRC_ID, default 0, 8-bit local node id placed in headers.
REQ-004 SHALL have port noc_clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports pkt_valid input 1, pkt_ready output 1, pkt_dest input 8, pkt_len input LEN_W: packet command (dest node, payload word count).
REQ-007 SHALL have ports data_valid input 1, data_ready output 1, data_word input DATA_W: payload stream.
REQ-008 SHALL have ports Noc_sender_valid output 1, Noc_sender_ready input 1, Noc_sender_VCready input 1, Noc_sender_flit output DATA_W, Noc_sender_is_header output 1, Noc_sender_is_tail output 1: flit stream toward the Noc_bridge receive side.

Function
REQ-009 SHALL accept a command when pkt_valid && pkt_ready; pkt_ready high only in IDLE.
REQ-010 SHALL transfer a flit only in cycles where Noc_sender_valid && Noc_sender_ready && Noc_sender_VCready are all high.
REQ-011 SHALL hold flit, is_header and is_tail stable, and keep valid high, from assertion until transfer.
REQ-012 SHALL not make Noc_sender_valid combinationally dependent on Noc_sender_ready or Noc_sender_VCready.
REQ-013 SHALL use FSM IDLE -> HEAD -> BODY -> IDLE; HEAD -> IDLE directly when pkt_len==0 and the checksum feature is absent.
REQ-014 SHALL format the header flit as [DATA_W-1:DATA_W-8]=dest, [DATA_W-9:DATA_W-16]=SRC_ID, [LEN_W-1:0]=pkt_len, other bits 0; is_header=1.
REQ-015 SHALL present the header on the cycle after command acceptance (1-cycle latency).
REQ-016 SHALL in BODY emit one flit per accepted data word (data_valid && data_ready), data_ready = BODY && (output register empty || transfer this cycle).
REQ-017 SHALL sustain one flit per cycle while ready, VCready and data_valid stay high.
REQ-018 SHALL count remaining words with an LEN_W down-counter loaded from pkt_len; is_tail=1 on the final payload flit; no wrap below 0.
REQ-019 SHALL set both is_header and is_tail on the header flit when pkt_len==0 (single-flit packet) without the checksum feature.
REQ-020 SHALL treat deassertion of VCready as a stall identical to ready low; no flit is dropped or duplicated.
REQ-021 SHALL return to IDLE, with pkt_ready high, in the cycle after the tail flit transfers.

Reset
REQ-022 SHALL on rst drive pkt_ready=0, data_ready=0, Noc_sender_valid=0, is_header=0, is_tail=0, flit=0, counter=0, state=IDLE; pkt_ready=1 the cycle after rst falls.
REQ-023 SHALL abandon any in-progress packet on rst mid-packet; no tail is emitted afterwards.

Configuration
REQ-024 SHALL compile a trailing checksum flit only when NOC_PKT_CHECKSUM_EN is defined.
REQ-025 SHALL with NOC_PKT_CHECKSUM_EN append after the last payload word a flit equal to the XOR of all payload words (0 if pkt_len==0), which alone carries is_tail; FSM gains state CSUM between BODY and IDLE.
REQ-026 SHALL without NOC_PKT_CHECKSUM_EN emit exactly pkt_len+1 flits per packet with no XOR logic present.

Structure
REQ-027 SHALL take DATA_W and the header field offsets/widths (dest, src, len) from the shared Noc_parameters.v include.
REQ-028 SHALL implement the output holding register as sub-module noc_flit_reg (valid/ready register slice with header/tail sideband).

Verification
REQ-029 SHALL check: dest=0x05, len=3, words 0xA,0xB,0xC, ready=VCready=1 -> flits 0x05000003(hdr), 0xA, 0xB, 0xC(tail) on 4 consecutive cycles.
REQ-030 SHALL check: len=0, no checksum -> single flit 0x05000000 with is_header=is_tail=1.
REQ-031 SHALL check: len=4, VCready low for 3 cycles mid-body -> flit held stable, 5 flits total, order intact.
REQ-032 SHALL check: rst asserted after 2nd payload flit of len=5 -> valid=0 next cycle, no tail, next packet header correct.
REQ-033 SHALL check: with NOC_PKT_CHECKSUM_EN, words 0x1,0x2,0x4 -> 5 flits, last 0x7 with is_tail, word 0x4 is_tail=0.
REQ-034 SHALL check: back-to-back commands, data_valid toggling every cycle -> no bubble-induced loss, pkt_ready low until tail transfer.
